// File: rtl/conv_pkg.sv
// Shared definitions for the convolution write-back path: default pixel width,
// output-map geometry helpers and the assembler state encoding.
package conv_pkg;

  localparam int DATA_WIDTH = 16;

  function automatic int calc_oh(input int h, input int f);
    return h - f + 1;
  endfunction

  function automatic int calc_ow(input int w, input int f);
    return w - f + 1;
  endfunction

  function automatic int calc_half(input int ow);
    return ow / 2;
  endfunction

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_e;

endpackage

// File: rtl/conv_row_assembler_if.sv
// Handshake bundle between the convolution units, the row assembler and the
// next layer that consumes the finished feature map.
interface conv_row_assembler_if
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = conv_pkg::DATA_WIDTH,
  parameter int H          = 32,
  parameter int W          = 32,
  parameter int F          = 5
);
  localparam int OH   = calc_oh(H, F);
  localparam int OW   = calc_ow(W, F);
  localparam int HALF = calc_half(OW);

  logic                          start;
  logic                          in_valid;
  logic                          in_ready;
  logic [0:HALF*DATA_WIDTH-1]    in_data;
  logic [5:0]                    rowNumber;
  logic [5:0]                    column;
  logic [0:OH*OW*DATA_WIDTH-1]   fmap;
  logic                          fmap_valid;
  logic                          fmap_ready;
  logic                          busy;

  modport master (
    output start, in_valid, in_data, fmap_ready,
    input  in_ready, rowNumber, column, fmap, fmap_valid, busy
  );

  modport slave (
    input  start, in_valid, in_data, fmap_ready,
    output in_ready, rowNumber, column, fmap, fmap_valid, busy
  );

endinterface

// File: rtl/rf_position_counter.sv
// Row / half-row position counter; walks (0,0),(0,1),(1,0)..(ROWS-1,1) and
// wraps to (0,0) after the last position.
module rf_position_counter #(
  parameter int ROWS = 28
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear_i,
  input  logic       advance_i,
  output logic [5:0] row_o,
  output logic       col_o,
  output logic       last_o
);
  localparam logic [5:0] ROW_LAST = 6'(ROWS - 1);

  logic [5:0] row_q, row_d;
  logic       col_q, col_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_q <= '0;
      col_q <= 1'b0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear_i) begin
      row_d = '0;
      col_d = 1'b0;
    end else if (advance_i) begin
      if (last_o) begin
        row_d = '0;
        col_d = 1'b0;
      end else if (col_q) begin
        row_d = row_q + 6'd1;
        col_d = 1'b0;
      end else begin
        col_d = 1'b1;
      end
    end
  end

  assign last_o = (row_q == ROW_LAST) && col_q;
  assign row_o  = row_q;
  assign col_o  = col_q;

endmodule

// File: rtl/conv_row_assembler.sv
// Write-back end of the convolution datapath: gathers half-row result vectors
// into the output feature map and hands the finished map to the next layer.
module conv_row_assembler
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = conv_pkg::DATA_WIDTH,
  parameter int H          = 32,
  parameter int W          = 32,
  parameter int F          = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  conv_row_assembler_if.slave  bus
);
  localparam int OH        = calc_oh(H, F);
  localparam int OW        = calc_ow(W, F);
  localparam int HALF      = calc_half(OW);
  localparam int FMAP_BITS = OH * OW * DATA_WIDTH;
  localparam int IN_BITS   = HALF * DATA_WIDTH;
  localparam int IDXW      = $clog2(FMAP_BITS);
  localparam int INW       = $clog2(IN_BITS);

  state_e                 state_q, state_d;
  logic [0:FMAP_BITS-1]   fmap_q;
  logic                   cnt_clear, cnt_adv, cnt_last, wr_en;
  logic [5:0]             row;
  logic                   col;

  function automatic logic [IDXW-1:0] fmap_bit(input logic [5:0] r, input logic c,
                                               input int j);
    return IDXW'((int'(r) * OW + int'(c) * HALF + j) * DATA_WIDTH);
  endfunction

  function automatic logic [INW-1:0] in_bit(input int j);
    return INW'(j * DATA_WIDTH);
  endfunction

  rf_position_counter #(.ROWS(OH)) u_pos (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (cnt_clear),
    .advance_i (cnt_adv),
    .row_o     (row),
    .col_o     (col),
    .last_o    (cnt_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // in_ready is decoded from state_q, so in_valid alone qualifies a beat in COLLECT.
  always_comb begin
    state_d   = state_q;
    cnt_clear = 1'b0;
    cnt_adv   = 1'b0;
    wr_en     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = COLLECT;
          cnt_clear = 1'b1;
        end
      end
      COLLECT: begin
        if (bus.in_valid) begin
          wr_en   = 1'b1;
          cnt_adv = 1'b1;
          if (cnt_last) state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.fmap_ready) begin
          state_d   = bus.start ? COLLECT : IDLE;
          cnt_clear = bus.start;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Each beat lands at pixel offset row*OW + col*HALF, one pixel per loop step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fmap_q <= '0;
    end else if (wr_en) begin
      for (int j = 0; j < HALF; j++) begin
        fmap_q[fmap_bit(row, col, j) +: DATA_WIDTH] <= bus.in_data[in_bit(j) +: DATA_WIDTH];
      end
    end
  end

  assign bus.in_ready   = (state_q == COLLECT);
  assign bus.fmap_valid = (state_q == HOLD);
  assign bus.busy       = (state_q != IDLE);
  assign bus.rowNumber  = row;
  assign bus.column     = {5'b0, col};
  assign bus.fmap       = fmap_q;

endmodule

// File: tb/tb_conv_row_assembler.sv
// Randomised bench for conv_row_assembler against a beat-index reference model.
module tb_conv_row_assembler;
  localparam int DW     = 16;
  localparam int H      = 32;
  localparam int W      = 32;
  localparam int F      = 5;
  localparam int OH     = H - F + 1;
  localparam int OW     = W - F + 1;
  localparam int HALF   = OW / 2;
  localparam int NBEATS = 2 * OH;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  conv_row_assembler_if #(.DATA_WIDTH(DW), .H(H), .W(W), .F(F)) bus ();

  conv_row_assembler #(.DATA_WIDTH(DW), .H(H), .W(W), .F(F)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model: phase flags, beat index k (row = k/2, half = k%2), pixel store.
  logic [DW-1:0] m_pix [OH*OW];
  bit m_collect = 1'b0;
  bit m_hold    = 1'b0;
  int m_beat    = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int p = 0; p < OH*OW; p++) m_pix[p] = '0;
      m_collect = 1'b0;
      m_hold    = 1'b0;
      m_beat    = 0;
    end else if (m_collect) begin
      if (bus.in_valid) begin
        for (int j = 0; j < HALF; j++)
          m_pix[(m_beat/2)*OW + (m_beat%2)*HALF + j] = bus.in_data[j*DW +: DW];
        m_beat = m_beat + 1;
        if (m_beat == NBEATS) begin
          m_beat    = 0;
          m_collect = 1'b0;
          m_hold    = 1'b1;
        end
      end
    end else if (m_hold) begin
      if (bus.fmap_ready) begin
        m_hold = 1'b0;
        if (bus.start) begin
          m_collect = 1'b1;
          m_beat    = 0;
        end
      end
    end else if (bus.start) begin
      m_collect = 1'b1;
      m_beat    = 0;
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk_fmap();
    int bad;
    bad = -1;
    for (int p = 0; p < OH*OW; p++)
      if (bad < 0 && bus.fmap[p*DW +: DW] !== m_pix[p]) bad = p;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL fmap pixel %0d actual=%0h required=%0h", bad,
               bus.fmap[bad*DW +: DW], m_pix[bad]);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready",   longint'(bus.in_ready),   longint'(m_collect));
      chk("fmap_valid", longint'(bus.fmap_valid), longint'(m_hold));
      chk("busy",       longint'(bus.busy),       longint'(m_collect | m_hold));
      chk("rowNumber",  longint'(bus.rowNumber),  longint'(m_beat / 2));
      chk("column",     longint'(bus.column),     longint'(m_beat % 2));
      chk_fmap();
    end
  end

  function automatic logic [DW-1:0] pix(input int r, input int c);
    return bus.fmap[(r*OW + c)*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] gen(input int pat, input int b, input int j);
    case (pat)
      0:       return DW'((b/2)*OW + (b%2)*HALF + j);
      1:       return 16'hFFFF;
      default: return DW'($urandom);
    endcase
  endfunction

  task automatic fill_junk();
    for (int j = 0; j < HALF; j++) bus.in_data[j*DW +: DW] = DW'($urandom);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pulse();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic stream(input int pat, input int idle_pct, input bit spur_start,
                        input int nbeats);
    bit acc;
    for (int b = 0; b < nbeats; b++) begin
      acc = 1'b0;
      while (!acc) begin
        bus.in_valid = ($urandom_range(0, 99) >= idle_pct);
        bus.start    = spur_start && ($urandom_range(0, 9) == 0);
        for (int j = 0; j < HALF; j++)
          bus.in_data[j*DW +: DW] = bus.in_valid ? gen(pat, b, j) : DW'($urandom);
        acc = bus.in_valid;
        tick();
      end
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
  endtask

  task automatic pin_ramp(input string tag);
    chk({tag, "_p0_0"},   longint'(pix(0, 0)),   0);
    chk({tag, "_p27_27"}, longint'(pix(27, 27)), 783);
    chk({tag, "_p13_20"}, longint'(pix(13, 20)), 384);
    chk({tag, "_p5_3"},   longint'(pix(5, 3)),   143);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int not_ff;
    bus.start      = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.fmap_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("rst_fmap_zero", longint'(|bus.fmap), 0);
    chk("rst_busy",      longint'(bus.busy),  0);
    reset = 1'b1;
    tick();

    // Full ramp map, no gaps, consumer not ready.
    start_pulse();
    stream(0, 0, 1'b0, NBEATS);
    chk("hold_fv_rise", longint'(bus.fmap_valid), 1);
    chk("hold_in_ready", longint'(bus.in_ready), 0);
    pin_ramp("map1");

    // Spurious beats and start while holding.
    bus.in_valid = 1'b1;
    bus.start    = 1'b1;
    repeat (3) begin
      fill_junk();
      tick();
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    chk("hold_still_valid", longint'(bus.fmap_valid), 1);
    pin_ramp("hold_spur");

    bus.fmap_ready = 1'b1;
    tick();
    bus.fmap_ready = 1'b0;
    chk("idle_busy", longint'(bus.busy), 0);

    // Spurious beats in IDLE.
    bus.in_valid = 1'b1;
    repeat (3) begin
      fill_junk();
      tick();
    end
    bus.in_valid = 1'b0;
    pin_ramp("idle_spur");

    // Same ramp with 30% gaps and stray start pulses mid-map.
    start_pulse();
    stream(0, 30, 1'b1, NBEATS);
    chk("gap_fv", longint'(bus.fmap_valid), 1);
    pin_ramp("map2");

    // Back-to-back: release and restart on the same edge.
    bus.fmap_ready = 1'b1;
    bus.start      = 1'b1;
    tick();
    bus.fmap_ready = 1'b0;
    bus.start      = 1'b0;
    chk("b2b_fv",    longint'(bus.fmap_valid), 0);
    chk("b2b_ready", longint'(bus.in_ready),   1);
    chk("b2b_row",   longint'(bus.rowNumber),  0);
    chk("b2b_col",   longint'(bus.column),     0);
    stream(1, 20, 1'b0, NBEATS);
    not_ff = 0;
    for (int r = 0; r < OH; r++)
      for (int c = 0; c < OW; c++)
        if (pix(r, c) !== 16'hFFFF) not_ff++;
    chk("map3_all_ffff", not_ff, 0);

    bus.fmap_ready = 1'b1;
    tick();
    bus.fmap_ready = 1'b0;

    // Abort after 20 beats with reset.
    start_pulse();
    stream(2, 30, 1'b0, 20);
    chk("abort_row", longint'(bus.rowNumber), 10);
    reset = 1'b0;
    #1;
    chk("abort_fmap_zero", longint'(|bus.fmap),   0);
    chk("abort_busy",      longint'(bus.busy),     0);
    chk("abort_in_ready",  longint'(bus.in_ready), 0);
    tick();
    reset = 1'b1;
    tick();

    // Fresh random map after the abort.
    start_pulse();
    stream(2, 30, 1'b0, NBEATS);
    chk("final_fv", longint'(bus.fmap_valid), 1);
    bus.fmap_ready = 1'b1;
    tick();
    bus.fmap_ready = 1'b0;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_row_assembler.md
# conv_row_assembler

Collects the half-row result vectors produced by the convolution units and writes them into a complete output feature map register. It is the write-back end of the convolution datapath: it drives the `rowNumber`/`column` position that the receptive-field selector consumes, accepts one half-row of results per handshake, and presents the finished map to the next layer (pooling/activation) through a valid/ready handshake.

## Interface
- `DATA_WIDTH`, 16: bits per pixel/result.
- `H`, 32: input image height.
- `W`, 32: input image width.
- `F`, 5: filter size; derived `OH = H-F+1`, `OW = W-F+1`, `HALF = OW/2`. `OW` must be even; `OH` ≤ 64.

- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: begin assembling a new map.
- `in_valid` in 1: `in_data` holds one half-row of results.
- `in_ready` out 1: block accepts a half-row this cycle.
- `in_data` in `HALF*DATA_WIDTH`, `[0:HALF*DATA_WIDTH-1]`: element j at `[j*DATA_WIDTH +: DATA_WIDTH]`, j=0 leftmost pixel.
- `rowNumber` out 6: output row currently expected.
- `column` out 6: half currently expected (0 = left half, 1 = right half).
- `fmap` out `OH*OW*DATA_WIDTH`, `[0:...]`: pixel (r,c) at `[(r*OW+c)*DATA_WIDTH +: DATA_WIDTH]`.
- `fmap_valid` out 1: `fmap` complete and stable.
- `fmap_ready` in 1: consumer takes `fmap`.
- `busy` out 1: high in COLLECT or HOLD.

## Operation
- States: IDLE, COLLECT, HOLD.
- IDLE: `in_ready=0`, `fmap_valid=0`. `start=1` → COLLECT, row=0, col=0.
- COLLECT: `in_ready=1`. On `in_valid & in_ready`: write `in_data` into `fmap` at pixel offset `row*OW + col*HALF`, `HALF` pixels; then col 0→1, or col 1→0 with row+1.
- Final beat (row=OH-1, col=1) → HOLD; counters reset to 0.
- HOLD: `fmap_valid=1`, `in_ready=0`, `fmap` frozen. `fmap_ready=1` → IDLE, or → COLLECT if `start=1` in the same cycle (back-to-back maps).
- `start` ignored in COLLECT and in HOLD without `fmap_ready`.
- `in_valid` ignored outside COLLECT; no data is written.
- `rowNumber`/`column` always reflect the counters (zero-extended col), so the selector presents the matching receptive fields while the beat is pending.
- A new map overwrites `fmap` region by region. Pixels not yet rewritten keep the previous map's values until overwritten. `fmap` is only guaranteed while `fmap_valid=1`.
- Reset (any state, mid-map included): state IDLE, counters 0, `fmap` all zero, all outputs 0. Partial map is discarded.

## Timing
- All outputs registered or decoded from registered state only. No combinational path from `in_valid`/`fmap_ready`/`start` to any output.
- Accepted beat is visible in `fmap` and in the advanced `rowNumber`/`column` on the next rising edge.
- Throughput: one half-row per cycle. Minimum map time is `2*OH` cycles (56 at defaults) from the first COLLECT cycle.
- `fmap_valid` rises the cycle after the final beat. It stays high until the edge where `fmap_ready=1` is sampled.
- `start` → `in_ready` high: 1 cycle.

## Structure
- Shared package `conv_pkg`: `DATA_WIDTH`, derived `OH`/`OW`/`HALF` functions, and state encoding `IDLE/COLLECT/HOLD`.
- One sub-module, `rf_position_counter`: row/col counter with `clear`, `advance`, `last` outputs. The selector-side address generator reuses it.
- Write logic: a parameterised loop over `HALF` pixels with an indexed part-select on `row*OW + col*HALF`.

## Test plan
- Reset then `start`, 56 beats with `in_data` pixel j = `row*28 + col*14 + j`, `fmap_ready=0` → `fmap_valid` rises 1 cycle after beat 56; pixel (r,c) = `r*28+c` for all r,c; `in_ready=0` in HOLD.
- Random `in_valid` gaps (30% idle) → identical `fmap`. `rowNumber`/`column` advance only on accepted beats and sequence (0,0),(0,1),(1,0)…(27,1).
- In HOLD, `fmap_ready=1` and `start=1` in the same cycle → next cycle COLLECT, `rowNumber=0`, `column=0`, `fmap_valid=0`. Second map with pixel = `0xFFFF` fully replaces the first.
- Reset asserted after beat 20 → `fmap` all zero, `busy=0`, `in_ready=0` immediately. `start` then a full map → correct result, no residue from the aborted map.
- `in_valid=1` in IDLE and HOLD, and `start=1` mid-COLLECT → `fmap` and counters unchanged by the spurious inputs.
